bram_port_arbiter: RTL and testbench

- Shares the single 32-bit BRAM word port between two requesters: the row reader (read, 512b fetch as 16 words) and the row writer (write-back, 512b as 16 words).
- Sits between the row read/write sequencers and the top-level BRAM controller.
- Arbitrates per transaction, with an optional burst lock that keeps all 16 words of one row contiguous.
- Forwards the trig/done word handshake in both directions.

---
 rtl/bram_port_arbiter_pkg.sv | 14 +
 rtl/bram_port_arbiter_rr_arb2.sv | 16 +
 rtl/bram_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_bram_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_port_arbiter_pkg.sv
// bram_port_arbiter_pkg: state/owner encodings and defaults shared by the BRAM port arbiter
package bram_port_arbiter_pkg;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_RD   = 2'd1;
  localparam logic [1:0] OWN_WR   = 2'd2;
  localparam int LOCK_MAX_DEF = 16;
  localparam logic [15:0] TIMEOUT_LIMIT = 16'd4095;
endpackage

// File: rtl/bram_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; one-hot o_gnt matches the OWN_RD/OWN_WR codes
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_take,
  input  logic       i_force,
  input  logic       i_force_ptr,
  output logic [1:0] o_gnt
);
  logic ptr;
  assign o_gnt = &i_req ? {ptr, ~ptr} : i_req;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) ptr <= 1'b0;
    else ptr <= i_force ? i_force_ptr : (i_take && &i_req) ? ~ptr : ptr;
endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one BRAM word port between row reader and writer; BRAM_ARB_TIMEOUT_EN adds a WAIT watchdog and o_timeout
module bram_port_arbiter import bram_port_arbiter_pkg::*; #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rd_trig,
  input  logic              i_rd_lock,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_done,
  input  logic              i_wr_trig,
  input  logic              i_wr_lock,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_done,
  output logic              o_bram_trig,
  output logic              o_bram_we,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic [DATA_W-1:0] o_bram_wdata,
  input  logic [DATA_W-1:0] i_bram_rdata,
  input  logic              i_bram_done,
`ifdef BRAM_ARB_TIMEOUT_EN
  output logic              o_timeout,
`endif
  output logic [1:0]        o_owner
);
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_LIM = CW'(LOCK_MAX);
  state_t state, nxt;
  logic [1:0] own, gnt, gap;
  logic [CW-1:0] cnt;
  logic done_q, rise, own_trig, own_lock, take, rel, force_rr, arm, armed;
`ifdef BRAM_ARB_TIMEOUT_EN
  logic [15:0] wd;
  logic abort;
`endif
  assign rise = i_bram_done & ~done_q;
  assign own_trig = own == OWN_WR ? i_wr_trig : i_rd_trig;
  assign own_lock = own == OWN_WR ? i_wr_lock : i_rd_lock;
  rr_arb2 u_rr (
    .i_clk(i_clk), .i_rst(i_rst), .i_req({i_wr_trig, i_rd_trig}), .i_take(take),
    .i_force(force_rr), .i_force_ptr(own == OWN_RD), .o_gnt(gnt)
  );
  always_comb begin
    nxt = state;
    take = 1'b0;
    rel = 1'b0;
    force_rr = 1'b0;
    arm = 1'b0;
`ifdef BRAM_ARB_TIMEOUT_EN
    abort = 1'b0;
`endif
    case (state)
      S_IDLE: if (i_rd_trig || i_wr_trig) begin
        nxt = S_ISSUE;
        take = 1'b1;
      end
      S_ISSUE: nxt = S_WAIT;
      S_WAIT: begin
        if (rise) nxt = S_RELEASE;
`ifdef BRAM_ARB_TIMEOUT_EN
        else if (wd == TIMEOUT_LIMIT) begin
          nxt = S_IDLE;
          abort = 1'b1;
        end
`endif
      end
      S_RELEASE: begin
        // armed: locked owner dropped trig and has a short window to re-raise it
        if (armed) begin
          if (own_trig) nxt = S_ISSUE;
          else if (&gap) begin
            nxt = S_IDLE;
            rel = 1'b1;
          end
        end else if (!i_bram_done && (!own_trig || !own_lock)) begin
          if (own_lock && cnt < LOCK_LIM) arm = 1'b1;
          else begin
            nxt = S_IDLE;
            rel = 1'b1;
            force_rr = cnt >= LOCK_LIM;
          end
        end
      end
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= S_IDLE;
      own <= OWN_NONE;
      cnt <= '0;
      gap <= '0;
      armed <= 1'b0;
      done_q <= 1'b0;
      o_rd_data <= '0;
      o_rd_done <= 1'b0;
      o_wr_done <= 1'b0;
      o_bram_trig <= 1'b0;
      o_bram_we <= 1'b0;
      o_bram_addr <= '0;
      o_bram_wdata <= '0;
      o_owner <= OWN_NONE;
`ifdef BRAM_ARB_TIMEOUT_EN
      wd <= '0;
      o_timeout <= 1'b0;
`endif
    end else begin
      state <= nxt;
      done_q <= i_bram_done;
      o_rd_done <= 1'b0;
      o_wr_done <= 1'b0;
      armed <= nxt == S_RELEASE && (armed || arm);
      gap <= armed && nxt == S_RELEASE ? gap + 1'b1 : '0;
      if (take) own <= gnt;
      if (state == S_ISSUE) begin
        o_bram_trig <= 1'b1;
        o_bram_we <= own == OWN_WR;
        o_bram_addr <= own == OWN_WR ? i_wr_addr : i_rd_addr;
        o_bram_wdata <= i_wr_data;
        o_owner <= own;
      end
      if (state == S_WAIT && rise) begin
        o_bram_trig <= 1'b0;
        o_rd_done <= own == OWN_RD;
        o_wr_done <= own == OWN_WR;
        cnt <= cnt + 1'b1;
        if (own == OWN_RD) o_rd_data <= i_bram_rdata;
      end
      if (rel) begin
        cnt <= '0;
        own <= OWN_NONE;
        o_owner <= OWN_NONE;
      end
`ifdef BRAM_ARB_TIMEOUT_EN
      o_timeout <= abort;
      wd <= state == S_WAIT ? wd + 1'b1 : '0;
      if (abort) begin
        o_bram_trig <= 1'b0;
        o_rd_done <= own == OWN_RD;
        o_wr_done <= own == OWN_WR;
        if (own == OWN_RD) o_rd_data <= '0;
        cnt <= '0;
        own <= OWN_NONE;
        o_owner <= OWN_NONE;
      end
`endif
    end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed scenarios against a small BRAM responder model
module tb_bram_port_arbiter;
  logic i_clk = 1'b0, i_rst = 1'b1;
  logic i_rd_trig = 1'b0, i_rd_lock = 1'b0, o_rd_done;
  logic [12:0] i_rd_addr = '0;
  logic [31:0] o_rd_data;
  logic i_wr_trig = 1'b0, i_wr_lock = 1'b0, o_wr_done;
  logic [12:0] i_wr_addr = '0;
  logic [31:0] i_wr_data = '0;
  logic o_bram_trig, o_bram_we, i_bram_done = 1'b0;
  logic [12:0] o_bram_addr;
  logic [31:0] o_bram_wdata, i_bram_rdata = '0;
  logic [1:0] o_owner;
`ifdef BRAM_ARB_TIMEOUT_EN
  logic o_timeout;
`endif
  int checks = 0, errors = 0, rd_dones = 0, wr_dones = 0, viol = 0;
  int bram_lat = 3, bram_hold = 1, lat_cnt = 0, hold_cnt = 0;
  logic bram_en = 1'b1, trig_q = 1'b0;
  logic [31:0] rdata_fix = '0, last_rd = '0;
  logic acc_we[$];
  logic [12:0] acc_addr[$];
  logic [31:0] acc_wdata[$];

  bram_port_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_rd_trig(i_rd_trig), .i_rd_lock(i_rd_lock), .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data), .o_rd_done(o_rd_done),
    .i_wr_trig(i_wr_trig), .i_wr_lock(i_wr_lock), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .o_wr_done(o_wr_done),
    .o_bram_trig(o_bram_trig), .o_bram_we(o_bram_we), .o_bram_addr(o_bram_addr),
    .o_bram_wdata(o_bram_wdata), .i_bram_rdata(i_bram_rdata), .i_bram_done(i_bram_done),
`ifdef BRAM_ARB_TIMEOUT_EN
    .o_timeout(o_timeout),
`endif
    .o_owner(o_owner)
  );

  always #5 i_clk = ~i_clk;

  // BRAM controller model: done after bram_lat cycles of trig, held bram_hold cycles
  always @(posedge i_clk) begin
    if (hold_cnt > 0) begin
      hold_cnt <= hold_cnt - 1;
      if (hold_cnt == 1) i_bram_done <= 1'b0;
    end else if (o_bram_trig && bram_en) begin
      if (lat_cnt >= bram_lat - 1) begin
        i_bram_done <= 1'b1;
        i_bram_rdata <= rdata_fix;
        hold_cnt <= bram_hold;
        lat_cnt <= 0;
        acc_we.push_back(o_bram_we);
        acc_addr.push_back(o_bram_addr);
        acc_wdata.push_back(o_bram_wdata);
      end else lat_cnt <= lat_cnt + 1;
    end else lat_cnt <= 0;
  end

  always @(negedge i_clk) begin
    if (o_rd_done) rd_dones++;
    if (o_wr_done) wr_dones++;
    if (o_bram_trig && !trig_q && i_bram_done) viol++;
    trig_q = o_bram_trig;
  end

  task automatic rd_word(input logic [12:0] a, input logic lk);
    int n = 0;
    i_rd_addr = a;
    i_rd_lock = lk;
    i_rd_trig = 1'b1;
    do begin @(negedge i_clk); n++; end while (!o_rd_done && n < 2000);
    checks++;
    if (o_rd_done !== 1'b1) begin errors++; $display("FAIL rd_done_wait: addr %h got done=%b required 1", a, o_rd_done); end
    last_rd = o_rd_data;
    i_rd_trig = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic wr_word(input logic [12:0] a, input logic [31:0] d, input logic lk);
    int n = 0;
    i_wr_addr = a;
    i_wr_data = d;
    i_wr_lock = lk;
    i_wr_trig = 1'b1;
    do begin @(negedge i_clk); n++; end while (!o_wr_done && n < 2000);
    checks++;
    if (o_wr_done !== 1'b1) begin errors++; $display("FAIL wr_done_wait: addr %h got done=%b required 1", a, o_wr_done); end
    i_wr_trig = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    checks++;
    if ({o_bram_trig, o_bram_we, o_rd_done, o_wr_done} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b required 0000", {o_bram_trig, o_bram_we, o_rd_done, o_wr_done}); end
    checks++;
    if (o_owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d required 0", o_owner); end
    checks++;
    if ({o_bram_addr, o_bram_wdata, o_rd_data} !== 77'b0) begin errors++; $display("FAIL reset_data: got %h %h %h required zeros", o_bram_addr, o_bram_wdata, o_rd_data); end
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_single_read();
    int n = 0;
    rdata_fix = 32'hDEADBEEF;
    rd_dones = 0;
    acc_we.delete(); acc_addr.delete(); acc_wdata.delete();
    i_rd_addr = 13'h0100;
    i_rd_trig = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_bram_trig !== 1'b0) begin errors++; $display("FAIL sr_latency1: got trig=%b required 0", o_bram_trig); end
    @(negedge i_clk);
    checks++;
    if ({o_bram_trig, o_bram_we, o_bram_addr} !== {1'b1, 1'b0, 13'h0100}) begin errors++; $display("FAIL sr_issue: got trig=%b we=%b addr=%h required 1 0 0100", o_bram_trig, o_bram_we, o_bram_addr); end
    checks++;
    if (o_owner !== 2'd1) begin errors++; $display("FAIL sr_owner: got %0d required 1", o_owner); end
    do begin @(negedge i_clk); n++; end while (!o_rd_done && n < 50);
    checks++;
    if ({o_rd_done, o_rd_data} !== {1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL sr_data: got done=%b data=%h required 1 deadbeef", o_rd_done, o_rd_data); end
    i_rd_trig = 1'b0;
    repeat (4) @(negedge i_clk);
    checks++;
    if (o_owner !== 2'd0) begin errors++; $display("FAIL sr_owner_release: got %0d required 0", o_owner); end
    checks++;
    if (rd_dones !== 1) begin errors++; $display("FAIL sr_done_count: got %0d required 1", rd_dones); end
    checks++;
    if (o_rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_data_hold: got %h required deadbeef", o_rd_data); end
  endtask

  task automatic test_simultaneous();
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    rd_dones = 0; wr_dones = 0;
    acc_we.delete(); acc_addr.delete(); acc_wdata.delete();
    fork
      rd_word(13'h0040, 1'b0);
      wr_word(13'h0041, 32'h0BADF00D, 1'b0);
    join
    repeat (4) @(negedge i_clk);
    checks++;
    if (acc_addr.size() !== 2) begin errors++; $display("FAIL sim_count: got %0d accesses required 2", acc_addr.size()); end
    else begin
      checks++;
      if ({acc_we[0], acc_addr[0]} !== {1'b0, 13'h0040}) begin errors++; $display("FAIL sim_first_rd: got we=%b addr=%h required 0 0040", acc_we[0], acc_addr[0]); end
      checks++;
      if ({acc_we[1], acc_addr[1], acc_wdata[1]} !== {1'b1, 13'h0041, 32'h0BADF00D}) begin errors++; $display("FAIL sim_second_wr: got we=%b addr=%h data=%h required 1 0041 0badf00d", acc_we[1], acc_addr[1], acc_wdata[1]); end
    end
    checks++;
    if ({rd_dones, wr_dones} !== {32'd1, 32'd1}) begin errors++; $display("FAIL sim_dones: got rd=%0d wr=%0d required 1 1", rd_dones, wr_dones); end
  endtask

  task automatic test_burst_lock();
    rdata_fix = 32'hCAFE0001;
    acc_we.delete(); acc_addr.delete(); acc_wdata.delete();
    fork
      begin
        for (int k = 0; k < 17; k++) wr_word(13'h0200 + 13'(k), 32'hC0DE0000 + k, 1'b1);
        i_wr_lock = 1'b0;
      end
      begin
        repeat (2) @(negedge i_clk);
        rd_word(13'h0300, 1'b0);
      end
    join
    repeat (10) @(negedge i_clk);
    checks++;
    if (acc_addr.size() !== 18) begin errors++; $display("FAIL burst_count: got %0d accesses required 18", acc_addr.size()); end
    else begin
      for (int k = 0; k < 16; k++) begin
        checks++;
        if ({acc_we[k], acc_addr[k]} !== {1'b1, 13'h0200 + 13'(k)}) begin errors++; $display("FAIL burst_word%0d: got we=%b addr=%h required 1 %h", k, acc_we[k], acc_addr[k], 13'h0200 + 13'(k)); end
      end
      checks++;
      if (acc_wdata[15] !== 32'hC0DE000F) begin errors++; $display("FAIL burst_wdata15: got %h required c0de000f", acc_wdata[15]); end
      checks++;
      if ({acc_we[16], acc_addr[16]} !== {1'b0, 13'h0300}) begin errors++; $display("FAIL burst_rd_after16: got we=%b addr=%h required 0 0300", acc_we[16], acc_addr[16]); end
      checks++;
      if ({acc_we[17], acc_addr[17]} !== {1'b1, 13'h0210}) begin errors++; $display("FAIL burst_wr17: got we=%b addr=%h required 1 0210", acc_we[17], acc_addr[17]); end
    end
    checks++;
    if ({o_owner, last_rd} !== {2'd0, 32'hCAFE0001}) begin errors++; $display("FAIL burst_end: got owner=%0d rd=%h required 0 cafe0001", o_owner, last_rd); end
  endtask

  task automatic test_done_held();
    bram_hold = 5;
    wr_dones = 0; viol = 0;
    acc_we.delete(); acc_addr.delete(); acc_wdata.delete();
    wr_word(13'h0050, 32'h11111111, 1'b0);
    checks++;
    if (i_bram_done !== 1'b1) begin errors++; $display("FAIL held_still_high: got done=%b required 1", i_bram_done); end
    wr_word(13'h0051, 32'h22222222, 1'b0);
    repeat (8) @(negedge i_clk);
    checks++;
    if (wr_dones !== 2) begin errors++; $display("FAIL held_done_count: got %0d required 2", wr_dones); end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL held_issue_during_done: got %0d issues required 0", viol); end
    checks++;
    if (acc_addr.size() !== 2 || acc_addr[acc_addr.size()-1] !== 13'h0051) begin errors++; $display("FAIL held_accesses: got %0d accesses required 2 ending 0051", acc_addr.size()); end
    checks++;
    if (o_rd_data !== 32'hCAFE0001) begin errors++; $display("FAIL held_rd_hold: got %h required cafe0001", o_rd_data); end
    bram_hold = 1;
  endtask

  task automatic test_reset_in_wait();
    int n = 0;
    bram_en = 1'b0;
    i_rd_addr = 13'h00AA;
    i_rd_trig = 1'b1;
    do begin @(negedge i_clk); n++; end while (!o_bram_trig && n < 10);
    checks++;
    if (o_bram_trig !== 1'b1) begin errors++; $display("FAIL rw_issue: got trig=%b required 1", o_bram_trig); end
    repeat (3) @(negedge i_clk);
    rd_dones = 0;
    #2 i_rst = 1'b1;
    #1;
    checks++;
    if ({o_bram_trig, o_owner} !== 3'b000) begin errors++; $display("FAIL rw_async_drop: got trig=%b owner=%0d required 0 0", o_bram_trig, o_owner); end
    @(negedge i_clk);
    i_rd_trig = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    bram_en = 1'b1;
    repeat (3) @(negedge i_clk);
    checks++;
    if (rd_dones !== 0) begin errors++; $display("FAIL rw_no_done: got %0d pulses required 0", rd_dones); end
    rdata_fix = 32'h12345678;
    acc_we.delete(); acc_addr.delete(); acc_wdata.delete();
    rd_word(13'h00AB, 1'b0);
    checks++;
    if (last_rd !== 32'h12345678) begin errors++; $display("FAIL rw_next_data: got %h required 12345678", last_rd); end
    checks++;
    if (acc_addr.size() !== 1 || acc_addr[0] !== 13'h00AB) begin errors++; $display("FAIL rw_next_addr: got %0d accesses required 1 at 00ab", acc_addr.size()); end
  endtask

`ifdef BRAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    bram_en = 1'b0;
    i_rd_addr = 13'h0077;
    i_rd_trig = 1'b1;
    do begin @(negedge i_clk); n++; end while (!o_timeout && n < 6000);
    checks++;
    if (o_timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b required 1", o_timeout); end
    checks++;
    if ({o_rd_done, o_rd_data} !== {1'b1, 32'h0}) begin errors++; $display("FAIL to_done_data: got done=%b data=%h required 1 0", o_rd_done, o_rd_data); end
    checks++;
    if (n < 4090) begin errors++; $display("FAIL to_early: got %0d cycles required about 4097", n); end
    i_rd_trig = 1'b0;
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_owner, o_bram_trig, o_timeout} !== 4'b0) begin errors++; $display("FAIL to_idle: got owner=%0d trig=%b to=%b required 0", o_owner, o_bram_trig, o_timeout); end
    bram_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_burst_lock();
    test_done_held();
    test_reset_in_wait();
`ifdef BRAM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
